// File: rtl/ihc_pkg.sv
// ihc_pkg: shared widths and the data-index to Hamming-position map for the SEC-DED encoder and decoder.
package ihc_pkg;
  localparam int DATA_W = 32;
  localparam int PAR_W  = 6;
  localparam int CODE_W = 39;
  function automatic logic [PAR_W-1:0] data_pos(input int idx);
    logic [PAR_W-1:0] r;
    int n;
    r = '0;
    n = 0;
    for (int p = 1; p < CODE_W; p++)
      if ((p & (p - 1)) != 0) begin
        if (n == idx) r = PAR_W'(p);
        n++;
      end
    return r;
  endfunction
endpackage

// File: rtl/ihc_if.sv
// ihc_if: encoder data-in / codeword-out bundle.
interface ihc_if;
  import ihc_pkg::*;
  logic              in_valid;
  logic [DATA_W-1:0] data_in;
  logic              out_valid;
  logic [CODE_W-1:0] data_out;
  modport master (output in_valid, data_in, input out_valid, data_out);
  modport slave  (input in_valid, data_in, output out_valid, data_out);
endinterface

// File: rtl/ihc_encode.sv
// ihc_encode: combinational extended-Hamming encoder, data bits scattered to non-power-of-two positions.
module ihc_encode #(
  parameter int DATA_W = ihc_pkg::DATA_W,
  parameter int CODE_W = ihc_pkg::CODE_W
) (
  input  logic [DATA_W-1:0] data_i,
  output logic [CODE_W-1:0] code_o
);
  import ihc_pkg::*;
  logic [CODE_W-1:0] raw;
  logic [PAR_W-1:0]  syn;
  logic [PAR_W-1:0]  s;
  // Parity bits equal the XOR of the positions of all set data bits.
  always_comb begin
    raw = '0;
    for (int i = 0; i < DATA_W; i++) raw[data_pos(i)] = data_i[i];
    syn = '0;
    for (int p = 1; p < CODE_W; p++) syn = syn ^ ({PAR_W{raw[PAR_W'(p)]}} & PAR_W'(p));
    code_o = raw;
    s = syn;
    for (int j = 0; j < PAR_W; j++) begin
      code_o[PAR_W'(1 << j)] = s[0];
      s = s >> 1;
    end
    code_o[0] = ^code_o[CODE_W-1:1];
  end
endmodule

// File: rtl/ihc.sv
// ihc: registered SEC-DED encoder, one-cycle latency, no backpressure.
module ihc #(
  parameter int DATA_W = ihc_pkg::DATA_W,
  parameter int CODE_W = ihc_pkg::CODE_W
) (
  input  logic clk,
  input  logic rst_n,
  ihc_if.slave bus
);
  import ihc_pkg::*;
  logic [CODE_W-1:0] code, data_q, data_d;
  logic              valid_q, valid_d;
  ihc_encode #(.DATA_W(DATA_W), .CODE_W(CODE_W)) u_enc (
    .data_i(bus.data_in),
    .code_o(code)
  );
  assign data_d  = bus.in_valid ? code : data_q;
  assign valid_d = bus.in_valid;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  assign bus.data_out  = data_q;
  assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_ihc.sv
// tb_ihc: randomized scoreboard bench for ihc against a position-syndrome reference model.
module tb_ihc;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  logic [38:0] q[$];
  logic [38:0] last = '0;
  ihc_if bus ();
  ihc dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic is_pow2(input int k);
    return (k & (k - 1)) == 0;
  endfunction
  function automatic logic [38:0] model_enc(input logic [31:0] d);
    logic [38:0] c;
    logic [5:0] s;
    int n;
    c = '0; s = '0; n = 0;
    for (int k = 1; k < 39; k++)
      if (!is_pow2(k)) begin
        c[6'(k)] = d[5'(n)];
        if (d[5'(n)]) s = s ^ 6'(k);
        n++;
      end
    for (int i = 0; i < 6; i++) c[6'(1 << i)] = s[3'(i)];
    c[0] = ^c;
    return c;
  endfunction
  function automatic logic [5:0] syndrome(input logic [38:0] c);
    logic [5:0] s;
    s = '0;
    for (int k = 1; k < 39; k++) if (c[6'(k)]) s = s ^ 6'(k);
    return s;
  endfunction
  function automatic logic [31:0] extract(input logic [38:0] c);
    logic [31:0] d;
    int n;
    d = '0; n = 0;
    for (int k = 1; k < 39; k++)
      if (!is_pow2(k)) begin
        d[5'(n)] = c[6'(k)];
        n++;
      end
    return d;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic drive(input logic [31:0] d, input logic [38:0] e);
    bus.in_valid = 1'b1;
    bus.data_in = d;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    logic [38:0] e, f;
    int k;
    if (rst_n) begin
      if (bus.out_valid) begin
        if (q.size() == 0) chk("unexpected_valid", 64'(bus.out_valid), 64'(0));
        else begin
          e = q.pop_front();
          chk("stream", 64'(bus.data_out), 64'(e));
          k = $urandom_range(0, 38);
          f = bus.data_out ^ (39'(1) << k);
          chk("flip_syn", 64'(syndrome(f)), 64'(k));
          chk("flip_par", 64'(^f), 64'(1));
        end
        last = bus.data_out;
      end else chk("hold", 64'(bus.data_out), 64'(last));
    end
  end

  initial begin
    logic [31:0] d;
    bus.in_valid = 1'b0;
    bus.data_in = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_data", 64'(bus.data_out), 64'(0));
    chk("reset_valid", 64'(bus.out_valid), 64'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    drive(32'h0000_0000, 39'h00_0000_0000);
    drive(32'h0000_0001, 39'h00_0000_000F);
    drive(32'h0000_0002, 39'h00_0000_0033);
    drive(32'h8000_0000, 39'h41_0000_0014);
    idle();
    chk("pulse_end", 64'(bus.out_valid), 64'(0));
    chk("pulse_hold", 64'(bus.data_out), 64'h41_0000_0014);
    drive(32'hCAFE3475, model_enc(32'hCAFE3475));
    bus.in_valid = 1'b0;
    chk("cafe_valid", 64'(bus.out_valid), 64'(1));
    chk("cafe_extract", 64'(extract(bus.data_out)), 64'hCAFE3475);
    chk("cafe_syn", 64'(syndrome(bus.data_out)), 64'(0));
    chk("cafe_xor", 64'(^bus.data_out), 64'(0));
    idle();
    chk("single_off", 64'(bus.out_valid), 64'(0));
    idle();
    chk("single_hold", 64'(bus.data_out), 64'(model_enc(32'hCAFE3475)));
    for (int i = 0; i < 10000; i++) begin
      d = $urandom();
      drive(d, model_enc(d));
    end
    bus.data_in = 32'hDEAD_BEEF;
    #1 rst_n = 1'b0;
    q.delete();
    last = '0;
    #1;
    chk("midreset_data", 64'(bus.data_out), 64'(0));
    chk("midreset_valid", 64'(bus.out_valid), 64'(0));
    bus.in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("post_reset_quiet", 64'(bus.out_valid), 64'(0));
    end
    drive(32'hFFFF_FFFF, model_enc(32'hFFFF_FFFF));
    idle();
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    chk("drain", 64'(q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ihc.md
IHC -- requirements
Module: ihc

Interface
REQ-001 Parameter DATA_W, default 32: data word width; only 32 is required to be supported.
REQ-002 Parameter CODE_W, default 39: codeword width, DATA_W + 6 Hamming parity bits + 1 overall parity bit.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  data_in is qualified this cycle.
REQ-006 data_in  input  32  data word to encode.
REQ-007 out_valid  output  1  data_out holds a fresh codeword.
REQ-008 data_out  output  39  registered SEC-DED (extended Hamming) codeword.

Function
REQ-009 Codeword bit k, for k = 1..38, SHALL be Hamming position k.
- Positions 1, 2, 4, 8, 16, 32 are parity bits p1, p2, p4, p8, p16, p32.
- data_out[0] is the overall parity bit.
REQ-010 The data bits SHALL occupy the 32 non-power-of-two positions 3, 5, 6, 7, 9..15, 17..31, 33..38 in ascending order.
- data_in[0] maps to position 3; data_in[31] maps to position 38.
REQ-011 Parity bit p(2^i) SHALL be the XOR of all data positions whose index has bit i set (even parity).
REQ-012 data_out[0] SHALL be the XOR of codeword bits 1..38, so the XOR of the full 39-bit word is 0.
REQ-013 The encode logic SHALL be purely combinational; the result SHALL be registered.
- Latency: exactly 1 clock from the in_valid sample to the out_valid/data_out update.
REQ-014 On a rising edge with in_valid=1: data_out <= encode(data_in), out_valid <= 1.
REQ-015 On a rising edge with in_valid=0: out_valid <= 0, and data_out SHALL hold its previous value.
REQ-016 Back-to-back in_valid SHALL be accepted every cycle, with no stall and no backpressure.
REQ-017 Any data_in value SHALL be legal; all-zero and all-one inputs need no special casing.
- encode(0) = 0.

Reset
REQ-018 While rst_n=0: data_out = 0 and out_valid = 0, asynchronously and independent of clk.
REQ-019 Reset SHALL be released synchronously; the first capture occurs on the first rising edge after rst_n goes high.
REQ-020 A reset asserted mid-stream SHALL discard the pending codeword; no out_valid pulse follows reset release until a new in_valid.

Structure
REQ-021 A shared package ihc_pkg SHALL hold:
- constants DATA_W=32, PAR_W=6, CODE_W=39;
- a function mapping data index to Hamming position.
REQ-022 The combinational encoder SHALL be one sub-module, ihc_encode (data_in[31:0] -> code[38:0]).
- The top ihc contains only the output registers and the valid register.
REQ-023 ihc_encode SHALL be reusable by a future decoder; the syndrome is recomputed with the same position map.

Verification
REQ-024 Reset check: assert rst_n=0 mid-operation -> data_out=0 and out_valid=0 immediately, without waiting for a clock edge.
REQ-025 Single-bit encodes, in_valid=1, each checked one cycle later with out_valid=1:
- data_in=0x0000_0000 -> data_out=0x00_0000_0000;
- data_in=0x0000_0001 -> data_out=0x00_0000_000F;
- data_in=0x0000_0002 -> data_out=0x00_0000_0033;
- data_in=0x8000_0000 -> data_out=0x41_0000_0014.
REQ-026 data_in=32'hCAFE3475 -> on the next edge:
- extracting the data positions from data_out returns 0xCAFE3475;
- the 6-bit syndrome is 0;
- the XOR of all 39 bits is 0.
REQ-027 Random stream of 10k back-to-back words -> every output matches the reference model at latency 1.
- Flipping any single codeword bit yields a nonzero syndrome equal to that bit's position (position 0 flags overall parity only).
REQ-028 Valid handling:
- in_valid=1 for one cycle, then 0 -> out_valid pulses high for exactly one cycle;
- data_out holds afterward.
